dbus_arbiter: RTL and testbench
===============================

Name: dbus_arbiter

Overview:
Round-robin arbiter and sequencer for the shared data bus (Bus_addr/Bus_we/Bus_wdata/Bus_rdata) toward the bridge.
- Master 0 is the CPU load/store port. Master 1 is a secondary master (DMA or debug loader).
- The block grants one master at a time and drives its beats onto the bus.
- It applies the fixed bridge read latency and returns read data with a one-cycle valid pulse.
- It supports short locked bursts per grant.

Parameters:
RD_LAT, 1, cycles from read address on the bus to Bus_rdata valid; legal range 1..4.
MAX_BURST, 4, maximum beats per grant before forced re-arbitration; legal range 1..8.

Ports:
cpu_clk  input  1  system clock, all state on rising edge
cpu_rst  input  1  asynchronous, active-low reset
m0_req  input  1  master 0 beat request
m0_we  input  1  master 0 write (1) / read (0)
m0_addr  input  32  master 0 byte address
m0_wdata  input  32  master 0 write data
m0_last  input  1  master 0 final beat of burst
m0_gnt  output  1  master 0 beat accepted this cycle
m0_rvalid  output  1  master 0 read data valid pulse
m0_rdata  output  32  master 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_last, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1
Bus_addr  output  32  bus address
Bus_we  output  1  bus write strobe
Bus_wdata  output  32  bus write data
Bus_rdata  input  32  bus read data

Behaviour:
- Registered state: fsm in {IDLE, ACCESS, WAIT}, owner (1b), rr_last (1b), beat_cnt (3b), lat_cnt (2b).
- Reset (cpu_rst=0, async):
  - fsm=IDLE, owner=0, rr_last=1 (master 0 wins first tie), beat_cnt=0, lat_cnt=0.
  - All outputs 0.
  - Reset mid-burst or mid-read drops the transaction silently; no rvalid is issued afterwards.
- IDLE:
  - Bus outputs are 0 and no gnt is asserted.
  - If exactly one req is high, that master becomes owner.
  - If both are high, owner = ~rr_last.
  - Next state is ACCESS; beat_cnt=0.
- ACCESS:
  - Bus_addr and Bus_wdata are driven from the owner's inputs.
  - Bus_we = owner_we & owner_req.
  - owner_gnt = owner_req, combinational, in this cycle only.
  - If owner_req=0: go to IDLE, rr_last unchanged.
  - Write beat: completes in this cycle.
  - Read beat: go to WAIT with lat_cnt=RD_LAT-1.
- WAIT:
  - Bus_addr holds the latched read address; Bus_we=0.
  - If lat_cnt != 0, decrement lat_cnt.
  - If lat_cnt == 0: owner_rvalid=1 and owner_rdata=Bus_rdata in this cycle, and the beat completes.
- Beat completion:
  - The burst ends if the beat's last=1 or beat_cnt==MAX_BURST-1.
  - Burst end: go to IDLE and set rr_last=owner.
  - Otherwise: beat_cnt++ and go to ACCESS.
- Latency:
  - Write beat occupies 1 cycle.
  - Read beat occupies 1+RD_LAT cycles; rvalid comes RD_LAT cycles after gnt.
  - Arbitration adds 1 IDLE cycle per grant.
- Non-owner behaviour:
  - The non-owner never sees gnt or rvalid.
  - Its req must stay asserted, with its addr/we/wdata/last stable, until gnt.
  - Maximum wait is one full burst of the other master plus 1 cycle.
- Output gating:
  - m*_rdata is 0 whenever the matching rvalid is 0.
  - Bus_wdata is 0 outside ACCESS.
- Simultaneous events:
  - A req rising in the same cycle as the other master's burst end is evaluated in the following IDLE cycle.
  - At that point, round-robin gives priority to the master that did not own the last burst.

Test Plan:
- Single write, m0 only: addr=0x1000, wdata=0xDEADBEEF, last=1, RD_LAT=1 -> IDLE at cycle 0. ACCESS at cycle 1 with Bus_we=1, Bus_addr=0x1000, m0_gnt=1. Back in IDLE at cycle 2.
- Single read, m1 only: addr=0x2004, RD_LAT=2, bridge returns 0x12345678 -> m1_gnt at cycle 1. m1_rvalid=1 with m1_rdata=0x12345678 at cycle 3, and only at cycle 3.
- Simultaneous req from reset, both single writes -> m0 is granted first, m1 is granted 2 cycles later. On the next tie m0 wins again, since rr_last=1.
- m0 read burst of 6 beats with MAX_BURST=4, m1 req held -> 4 m0 rvalid pulses, then m1 is granted. m0's remaining beats are granted only after m1's burst ends.
- m1 drops req while in ACCESS -> no Bus_we, no gnt, return to IDLE. m0 is then granted normally.
- cpu_rst asserted during WAIT of an m0 read -> all outputs 0 immediately. No m0_rvalid after release. First grant after release is m0 on a tie.

Source files
------------

// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - two-master round-robin arbiter and sequencer for the shared bridge data bus
//
// Purpose: grants the bus to one master at a time (m0 = CPU load/store port,
// m1 = DMA / debug loader), drives the owner's beats onto Bus_*, waits out the
// fixed bridge read latency and returns read data with a one-cycle rvalid pulse.
// A grant covers a locked burst of up to MAX_BURST beats.
//
// Ports:
//   cpu_clk, cpu_rst          clock, asynchronous active-low reset
//   mN_req/we/addr/wdata/last per-master beat request (held until mN_gnt)
//   mN_gnt                    beat accepted this cycle (combinational)
//   mN_rvalid, mN_rdata       read data pulse; rdata is 0 when rvalid is 0
//   Bus_addr/we/wdata         bus toward the bridge
//   Bus_rdata                 bridge read data, valid RD_LAT cycles after the address
module dbus_arbiter #(
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_last,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_last,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] Bus_addr,
    output logic        Bus_we,
    output logic [31:0] Bus_wdata,
    input  logic [31:0] Bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);
    localparam logic [2:0] BEAT_MAX = 3'(MAX_BURST - 1);

    state_t      fsm_q, fsm_d;
    logic        owner_q, owner_d;
    logic        rr_last_q, rr_last_d;
    logic [2:0]  beat_cnt_q, beat_cnt_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    // Read beats release the master at gnt, so the address and last flag are
    // captured for the WAIT phase rather than read from the master's inputs.
    logic [31:0] rd_addr_q, rd_addr_d;
    logic        rd_last_q, rd_last_d;

    logic        own_req;
    logic        own_we;
    logic [31:0] own_addr;
    logic [31:0] own_wdata;
    logic        own_last;

    logic        gnt;
    logic        rvalid;
    logic        beat_done;
    logic        beat_last;

    assign own_req   = owner_q ? m1_req   : m0_req;
    assign own_we    = owner_q ? m1_we    : m0_we;
    assign own_addr  = owner_q ? m1_addr  : m0_addr;
    assign own_wdata = owner_q ? m1_wdata : m0_wdata;
    assign own_last  = owner_q ? m1_last  : m0_last;

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            fsm_q      <= IDLE;
            owner_q    <= 1'b0;
            rr_last_q  <= 1'b1;
            beat_cnt_q <= 3'd0;
            lat_cnt_q  <= 2'd0;
            rd_addr_q  <= 32'd0;
            rd_last_q  <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            beat_cnt_q <= beat_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_last_q  <= rd_last_d;
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        beat_cnt_d = beat_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        rd_addr_d  = rd_addr_q;
        rd_last_d  = rd_last_q;
        Bus_addr   = 32'd0;
        Bus_we     = 1'b0;
        Bus_wdata  = 32'd0;
        gnt        = 1'b0;
        rvalid     = 1'b0;
        beat_done  = 1'b0;
        beat_last  = 1'b0;

        case (fsm_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // On a tie the master that did not own the last burst wins.
                    owner_d    = (m0_req && m1_req) ? ~rr_last_q : m1_req;
                    fsm_d      = ACCESS;
                    beat_cnt_d = 3'd0;
                end
            end
            ACCESS: begin
                Bus_addr  = own_addr;
                Bus_wdata = own_wdata;
                Bus_we    = own_we & own_req;
                gnt       = own_req;
                if (!own_req) begin
                    // Owner withdrew: give the bus up without touching rr_last.
                    fsm_d = IDLE;
                end else if (own_we) begin
                    beat_done = 1'b1;
                    beat_last = own_last;
                end else begin
                    fsm_d     = WAIT;
                    lat_cnt_d = LAT_INIT;
                    rd_addr_d = own_addr;
                    rd_last_d = own_last;
                end
            end
            WAIT: begin
                Bus_addr = rd_addr_q;
                if (lat_cnt_q != 2'd0) begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end else begin
                    rvalid    = 1'b1;
                    beat_done = 1'b1;
                    beat_last = rd_last_q;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase

        if (beat_done) begin
            if (beat_last || (beat_cnt_q == BEAT_MAX)) begin
                fsm_d     = IDLE;
                rr_last_d = owner_q;
            end else begin
                fsm_d      = ACCESS;
                beat_cnt_d = beat_cnt_q + 3'd1;
            end
        end
    end

    assign m0_gnt    = gnt & ~owner_q;
    assign m1_gnt    = gnt & owner_q;
    assign m0_rvalid = rvalid & ~owner_q;
    assign m1_rvalid = rvalid & owner_q;
    assign m0_rdata  = m0_rvalid ? Bus_rdata : 32'd0;
    assign m1_rdata  = m1_rvalid ? Bus_rdata : 32'd0;

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb/tb_dbus_arbiter.sv - self-checking bench for dbus_arbiter (RD_LAT=2, MAX_BURST=4)
module tb_dbus_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] Z = 32'h0;
    localparam logic [132:0] NONE = '0;
    localparam logic [31:0] RD_XOR = 32'hA5A5_0000;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b0;
    logic        m0_req, m0_we, m0_last, m1_req, m1_we, m1_last;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, Bus_we;
    logic [31:0] m0_rdata, m1_rdata, Bus_addr, Bus_wdata;
    wire  [31:0] Bus_rdata;
    logic        rd_mode = 1'b0;
    wire [132:0] obs;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        r0, w0, l0, r1, w1, l1;
        logic [31:0] a0, d0, a1, d1;
        logic [132:0] exp;
    } vec_t;

    vec_t tbl[25];

    always #5 cpu_clk = ~cpu_clk;

    // Bridge model: fixed word, or an address-derived word for the burst test.
    assign Bus_rdata = rd_mode ? (Bus_addr ^ RD_XOR) : 32'h1234_5678;
    assign obs = {m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata, Bus_addr, Bus_we, Bus_wdata};

    dbus_arbiter #(.RD_LAT(2), .MAX_BURST(4)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_last(m0_last),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_last(m1_last),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .Bus_addr(Bus_addr), .Bus_we(Bus_we), .Bus_wdata(Bus_wdata), .Bus_rdata(Bus_rdata)
    );

    function automatic logic [132:0] ex(input logic g0, v0, input logic [31:0] rd0,
                                        input logic g1, v1, input logic [31:0] rd1, ba,
                                        input logic we, input logic [31:0] wd);
        return {g0, v0, rd0, g1, v1, rd1, ba, we, wd};
    endfunction

    function automatic vec_t mk(input logic r0, w0, input logic [31:0] a0, d0, input logic l0,
                                input logic r1, w1, input logic [31:0] a1, d1, input logic l1,
                                input logic [132:0] e);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.l1 = l1;
        v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [132:0] act, input logic [132:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0; m0_last = v.l0;
        m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1; m1_last = v.l1;
    endtask

    task automatic idle_inputs();
        drive(mk(L, L, Z, Z, L, L, L, Z, Z, L, NONE));
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(tbl[i]);
            @(negedge cpu_clk);
            chk($sformatf("row%0d", i), obs, tbl[i].exp);
            @(posedge cpu_clk);
            #1;
        end
    endtask

    initial begin
        logic [24:0] eg0;
        logic [24:0] ev0;
        int          beat;
        int          vk;

        // Single m0 write
        tbl[0]  = mk(H, H, 32'h1000, 32'hDEADBEEF, H, L, L, Z, Z, L, NONE);
        tbl[1]  = mk(H, H, 32'h1000, 32'hDEADBEEF, H, L, L, Z, Z, L, ex(H, L, Z, L, L, Z, 32'h1000, H, 32'hDEADBEEF));
        tbl[2]  = mk(L, L, Z, Z, L, L, L, Z, Z, L, NONE);
        // Single m1 read, RD_LAT=2
        tbl[3]  = mk(L, L, Z, Z, L, H, L, 32'h2004, Z, H, NONE);
        tbl[4]  = mk(L, L, Z, Z, L, H, L, 32'h2004, Z, H, ex(L, L, Z, H, L, Z, 32'h2004, L, Z));
        tbl[5]  = mk(L, L, Z, Z, L, L, L, Z, Z, L, ex(L, L, Z, L, L, Z, 32'h2004, L, Z));
        tbl[6]  = mk(L, L, Z, Z, L, L, L, Z, Z, L, ex(L, L, Z, L, H, 32'h1234_5678, 32'h2004, L, Z));
        tbl[7]  = mk(L, L, Z, Z, L, L, L, Z, Z, L, NONE);
        // Tie with rr_last=1: m0 first, m1 two cycles later
        tbl[8]  = mk(H, H, 32'h3000, 32'h1111_1111, H, H, H, 32'h4000, 32'h2222_2222, H, NONE);
        tbl[9]  = mk(H, H, 32'h3000, 32'h1111_1111, H, H, H, 32'h4000, 32'h2222_2222, H, ex(H, L, Z, L, L, Z, 32'h3000, H, 32'h1111_1111));
        tbl[10] = mk(L, L, Z, Z, L, H, H, 32'h4000, 32'h2222_2222, H, NONE);
        tbl[11] = mk(L, L, Z, Z, L, H, H, 32'h4000, 32'h2222_2222, H, ex(L, L, Z, H, L, Z, 32'h4000, H, 32'h2222_2222));
        tbl[12] = mk(L, L, Z, Z, L, L, L, Z, Z, L, NONE);
        // Next tie: m0 wins again
        tbl[13] = tbl[8];
        tbl[14] = tbl[9];
        tbl[15] = tbl[10];
        tbl[16] = tbl[11];
        tbl[17] = tbl[12];
        // m1 drops req in ACCESS, then m0 granted normally
        tbl[18] = mk(L, L, Z, Z, L, H, H, 32'h7000, 32'h4444_4444, H, NONE);
        tbl[19] = mk(H, H, 32'h8000, 32'h5555_5555, H, L, H, 32'h7000, 32'h4444_4444, H, ex(L, L, Z, L, L, Z, 32'h7000, L, 32'h4444_4444));
        tbl[20] = mk(H, H, 32'h8000, 32'h5555_5555, H, L, L, Z, Z, L, NONE);
        tbl[21] = mk(H, H, 32'h8000, 32'h5555_5555, H, L, L, Z, Z, L, ex(H, L, Z, L, L, Z, 32'h8000, H, 32'h5555_5555));
        tbl[22] = mk(L, L, Z, Z, L, L, L, Z, Z, L, NONE);
        // m0 read to be cut by reset
        tbl[23] = mk(H, L, 32'h9000, Z, H, L, L, Z, Z, L, NONE);
        tbl[24] = mk(H, L, 32'h9000, Z, H, L, L, Z, Z, L, ex(H, L, Z, L, L, Z, 32'h9000, L, Z));

        idle_inputs();
        repeat (2) @(negedge cpu_clk);
        chk("reset_state", obs, NONE);
        @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b1;

        apply_rows(0, 17);

        // m0 6-beat read burst against a held m1 write; MAX_BURST=4 splits it.
        eg0 = '0;
        ev0 = '0;
        eg0[1] = 1'b1; eg0[4] = 1'b1; eg0[7] = 1'b1; eg0[10] = 1'b1; eg0[16] = 1'b1; eg0[19] = 1'b1;
        ev0[3] = 1'b1; ev0[6] = 1'b1; ev0[9] = 1'b1; ev0[12] = 1'b1; ev0[18] = 1'b1; ev0[21] = 1'b1;
        rd_mode = 1'b1;
        beat = 0;
        vk = 0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h6000; m1_wdata = 32'h3333_3333; m1_last = 1'b1;
        for (int c = 0; c < 25; c++) begin
            m0_req   = (beat < 6);
            m0_we    = 1'b0;
            m0_addr  = 32'h5000 + 32'(4 * beat);
            m0_wdata = 32'h0;
            m0_last  = (beat == 5);
            @(negedge cpu_clk);
            chk32($sformatf("burst_m0_gnt_c%0d", c), {31'b0, m0_gnt}, {31'b0, eg0[c]});
            chk32($sformatf("burst_m0_rvalid_c%0d", c), {31'b0, m0_rvalid}, {31'b0, ev0[c]});
            chk32($sformatf("burst_m1_gnt_c%0d", c), {31'b0, m1_gnt}, {31'b0, (c == 14)});
            if (ev0[c]) begin
                chk32($sformatf("burst_rdata_beat%0d", vk), m0_rdata, (32'h5000 + 32'(4 * vk)) ^ RD_XOR);
                vk++;
            end else begin
                chk32($sformatf("burst_rdata_gated_c%0d", c), m0_rdata, Z);
            end
            @(posedge cpu_clk);
            #1;
            if (eg0[c]) beat++;
            if (c == 14) m1_req = 1'b0;
        end
        rd_mode = 1'b0;

        apply_rows(18, 24);

        // Now in WAIT of the m0 read; reset must drop it with no later rvalid.
        chk32("wait_bus_addr", Bus_addr, 32'h9000);
        cpu_rst = 1'b0;
        #1;
        chk("reset_async_outputs", obs, NONE);
        idle_inputs();
        @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge cpu_clk);
            chk($sformatf("post_reset_quiet_c%0d", c), obs, NONE);
        end
        @(posedge cpu_clk);
        #1;
        // Tie after reset goes to m0 again.
        apply_rows(8, 9);
        idle_inputs();
        repeat (2) @(posedge cpu_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
